// File: rtl/blockade_sample_player.sv
// Sound-sample playback engine: reads a 4-byte header from the sound ROM and then streams
// 8-bit unsigned PCM as signed 16-bit audio. Each sample is held for CLK_DIV clocks.
module blockade_sample_player #(
    parameter int CLK_DIV = 1000,
    parameter int NUM_IDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [2:0]  sample_id,
    input  logic        stop,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] audio_out,
    output logic        busy
);
    localparam int DIV_W = $clog2(CLK_DIV);

    // HCHK is the single cycle after the last header byte where the length is inspected.
    typedef enum logic [3:0] {
        IDLE, H0, H1, H2, H3, HCHK, FETCH, READY, DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             phase_q, phase_d;  // 0: address on the bus, 1: rom_data valid
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      remaining_q, remaining_d;
    logic [15:0]      rom_addr_q, rom_addr_d;
    logic [15:0]      audio_q, audio_d;
    logic [7:0]       pending_q, pending_d;
    logic             busy_q, busy_d;
    logic [15:0]      hdr_base;

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign hdr_base = {11'd0, sample_id & 3'(NUM_IDS - 1), 2'b00};

    // The sample clock is free-running; a new trigger never realigns it.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_comb begin
        // NOTE: every target gets its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rom_addr_d  = rom_addr_q;
        audio_d     = audio_q;
        pending_d   = pending_q;
        busy_d      = busy_q;

        if (trigger) begin
            state_d    = H0;
            phase_d    = 1'b0;
            busy_d     = 1'b1;
            audio_d    = '0;
            rom_addr_d = hdr_base;
        end else if (stop && state_q != IDLE) begin
            state_d = IDLE;
            phase_d = 1'b0;
            busy_d  = 1'b0;
            audio_d = '0;
        end else begin
            case (state_q)
                H0: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        addr_d[15:8] = rom_data;
                        rom_addr_d   = rom_addr_q + 16'd1;
                        state_d      = H1;
                    end
                end
                H1: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        addr_d[7:0] = rom_data;
                        rom_addr_d  = rom_addr_q + 16'd1;
                        state_d     = H2;
                    end
                end
                H2: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        remaining_d[15:8] = rom_data;
                        rom_addr_d        = rom_addr_q + 16'd1;
                        state_d           = H3;
                    end
                end
                H3: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        remaining_d[7:0] = rom_data;
                        state_d          = HCHK;
                    end
                end
                HCHK: begin
                    if (remaining_q == 16'd0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = FETCH;
                        rom_addr_d = addr_q;
                    end
                end
                FETCH: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        pending_d = rom_data;
                        state_d   = READY;
                    end
                end
                READY: begin
                    if (tick) begin
                        // Flipping the MSB turns offset-binary PCM into two's complement.
                        audio_d     = {~pending_q[7], pending_q[6:0], 8'h00};
                        addr_d      = addr_q + 16'd1;
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = DRAIN;
                        end else begin
                            state_d    = FETCH;
                            rom_addr_d = addr_q + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        audio_d = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use <= so every register samples pre-edge values; reset is
    // synchronous and clears all of them, the pending sample included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            audio_q     <= '0;
            pending_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rom_addr_q  <= rom_addr_d;
            audio_q     <= audio_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign audio_out = audio_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_blockade_sample_player.sv
// Bench for blockade_sample_player: directed scenarios plus random trigger/stop/reset traffic,
// each cycle compared against a timeline model of playback built from the header rules.
module tb_blockade_sample_player;
    localparam int CLK_DIV = 16;
    localparam int NUM_IDS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [2:0]  sample_id;
    logic        stop;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] audio_out;
    logic        busy;

    logic [7:0]  rom [0:65535];

    int total = 0;
    int bad   = 0;

    // Reference model state: a playback is a header plus a count of samples already emitted.
    int          cyc = 0;
    int          since_reset = 0;
    logic        m_busy = 1'b0;
    logic [15:0] m_audio = '0;
    int          m_start, m_len, m_played, m_hdr_done, m_ready;

    // Observation helpers for the directed checks.
    logic [15:0] prev_audio = '0;
    int          run_len = 0;
    logic [15:0] seen_q[$];
    int          hold_q[$];
    bit          wrap_seen = 1'b0;

    blockade_sample_player #(.CLK_DIV(CLK_DIV), .NUM_IDS(NUM_IDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .sample_id (sample_id),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .audio_out (audio_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pcm_to_audio(input logic [7:0] b);
        return 16'((int'(b) - 128) * 256);
    endfunction

    // Header accepted at edge t: bytes read over t+1..t+8, length judged at t+9, first byte
    // fetched by t+11, so the first sample can leave on a tick at t+12 or later.
    task automatic model_step(input logic trg, input logic [2:0] id, input logic stp,
                              input logic rst);
        bit tk;
        int base;
        if (rst) begin
            m_busy      = 1'b0;
            m_audio     = '0;
            since_reset = 0;
        end else begin
            tk = (since_reset % CLK_DIV) == CLK_DIV - 1;
            since_reset++;
            if (trg) begin
                base       = (int'(id) % NUM_IDS) * 4;
                m_start    = int'(rom[base]) * 256 + int'(rom[base + 1]);
                m_len      = int'(rom[base + 2]) * 256 + int'(rom[base + 3]);
                m_played   = 0;
                m_hdr_done = cyc + 9;
                m_ready    = cyc + 12;
                m_busy     = 1'b1;
                m_audio    = '0;
            end else if (stp && m_busy) begin
                m_busy  = 1'b0;
                m_audio = '0;
            end else if (m_busy) begin
                if (m_len == 0) begin
                    if (cyc == m_hdr_done) m_busy = 1'b0;
                end else if (m_played < m_len) begin
                    if (tk && cyc >= m_ready) begin
                        m_audio = pcm_to_audio(rom[(m_start + m_played) % 65536]);
                        m_played++;
                        m_ready = cyc + 3;
                    end
                end else if (tk) begin
                    m_audio = '0;
                    m_busy  = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input logic trg, input logic [2:0] id, input logic stp, input logic rst);
        trigger   = trg;
        sample_id = id;
        stop      = stp;
        reset     = rst;
        @(posedge clk);
        model_step(trg, id, stp, rst);
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("audio_out", 32'(audio_out), 32'(m_audio));
        if (audio_out !== prev_audio) begin
            seen_q.push_back(audio_out);
            hold_q.push_back(run_len);
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_audio = audio_out;
        if (busy && rom_addr == 16'h0000) wrap_seen = 1'b1;
    endtask

    task automatic run_idle(input int cnt);
        repeat (cnt) step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_audio(input logic [15:0] v, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            if (audio_out === v) found = 1'b1;
        end
    endtask

    task automatic set_hdr(input int id, input logic [15:0] start, input logic [15:0] len);
        rom[id * 4]     = start[15:8];
        rom[id * 4 + 1] = start[7:0];
        rom[id * 4 + 2] = len[15:8];
        rom[id * 4 + 3] = len[7:0];
    endtask

    initial begin
        bit found;
        int cnt;
        int r;

        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        set_hdr(0, 16'h8050, 16'd2);
        set_hdr(1, 16'h0020, 16'd3);
        set_hdr(2, 16'h0100, 16'd0);
        set_hdr(3, 16'h0040, 16'd1);
        set_hdr(4, 16'hFFFF, 16'd2);
        for (int i = 5; i < 8; i++) begin
            set_hdr(i, 16'($urandom_range(16'h0100, 16'hF000)), 16'($urandom_range(0, 3)));
        end
        rom[16'h0020] = 8'h80;
        rom[16'h0021] = 8'hFF;
        rom[16'h0022] = 8'h00;
        rom[16'h0040] = 8'hC0;
        rom[16'hFFFF] = 8'hFF;

        // Reset state
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Three-sample playback, then drain to silence
        seen_q.delete();
        hold_q.delete();
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check("t1_busy_next", 32'(busy), 32'h1);
        run_idle(90);
        check("t1_n_changes", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            check("t1_second", 32'(seen_q[0]), 32'h7F00);
            check("t1_third", 32'(seen_q[1]), 32'h8000);
            check("t1_drain", 32'(seen_q[2]), 32'h0000);
            check("t1_hold_7f00", 32'(hold_q[1]), 32'(CLK_DIV));
            check("t1_hold_8000", 32'(hold_q[2]), 32'(CLK_DIV));
        end
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Zero-length header: busy for the accept edge plus the header read
        step(1'b1, 3'd2, 1'b0, 1'b0);
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            if (busy) cnt++;
        end
        check("t2_busy_cycles", 32'(cnt), 32'd9);
        check("t2_audio", 32'(audio_out), 32'h0);

        // Retrigger during playback
        step(1'b1, 3'd1, 1'b0, 1'b0);
        wait_audio(16'h7F00, 60, found);
        check("t3_7f00_seen", 32'(found), 32'h1);
        run_idle(4);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        check("t3_cleared", 32'(audio_out), 32'h0);
        check("t3_busy_kept", 32'(busy), 32'h1);
        wait_audio(16'h4000, 60, found);
        check("t3_4000_seen", 32'(found), 32'h1);
        run_idle(40);
        check("t3_end_busy", 32'(busy), 32'h0);
        check("t3_end_audio", 32'(audio_out), 32'h0);

        // Stop mid-sample, replay, then trigger+stop together
        step(1'b1, 3'd1, 1'b0, 1'b0);
        run_idle(40);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("t4_stop_busy", 32'(busy), 32'h0);
        check("t4_stop_audio", 32'(audio_out), 32'h0);
        run_idle(3);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        wait_audio(16'h4000, 60, found);
        check("t4_replay_seen", 32'(found), 32'h1);
        run_idle(40);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        run_idle(30);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        check("t4_both_busy", 32'(busy), 32'h1);
        wait_audio(16'h4000, 60, found);
        check("t4_both_seen", 32'(found), 32'h1);
        run_idle(40);

        // Address wrap from 0xFFFF to 0x0000
        seen_q.delete();
        hold_q.delete();
        wrap_seen = 1'b0;
        step(1'b1, 3'd4, 1'b0, 1'b0);
        run_idle(90);
        check("t5_wrap_seen", 32'(wrap_seen), 32'h1);
        check("t5_n_changes", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t5_first", 32'(seen_q[0]), 32'h7F00);
            check("t5_second", 32'(seen_q[1]), 32'h0000);
            check("t5_hold_7f00", 32'(hold_q[1]), 32'(CLK_DIV));
        end

        // Reset during READY restarts the divider
        step(1'b1, 3'd1, 1'b0, 1'b0);
        run_idle(13);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("t6_rom_addr", 32'(rom_addr), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_audio", 32'(audio_out), 32'h0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        cnt = 1;
        while (audio_out !== 16'h4000 && cnt < 100) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            cnt++;
        end
        check("t6_first_tick", 32'(cnt), 32'(CLK_DIV));
        run_idle(40);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            step(r < 20, 3'($urandom_range(0, 7)), r >= 16 && r < 26, r == 999);
        end
        run_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
